// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues sequential reads to a 1-cycle instruction memory and
// buffers the responses in a prefetch FIFO drained by decode, with redirect and error hold.
module fetch_queue #(
    parameter int                ADDR_W   = 16,
    parameter int                INST_W   = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_INC   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              illegal_op,
    input  logic [ADDR_W-1:0] illegal_pc,
    input  logic              return_execution,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              imem_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err,
    output logic [ADDR_W-1:0] epc
);

    localparam int                PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {
        RUN,
        ERR_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              inflight_q, inflight_d;
    logic              squash_q, squash_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic              err_mem_q  [DEPTH];

    logic              redirect;
    logic [ADDR_W-1:0] new_pc;
    logic              room;
    logic              push;
    logic              pop;

    // Redirect source selection; return_execution uses the epc value from before this cycle.
    always_comb begin
        redirect = branch_taken | illegal_op | return_execution;
        new_pc   = epc_q;
        if (branch_taken) begin
            new_pc = branch_target;
        end else if (illegal_op) begin
            new_pc = EXC_VEC;
        end
    end

    // Space check counts the outstanding response so a push can never overflow.
    always_comb begin
        room = (count_q + CNT_W'(inflight_q)) < DEPTH_C;
        push = rst_n & inflight_q & ~squash_q & ~redirect;
        pop  = inst_valid & inst_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = RUN;
        end else if (push && imem_err) begin
            state_d = ERR_HOLD;
        end
    end

    always_comb begin
        imem_req  = rst_n & (state_q == RUN) & ~redirect & room;
        imem_addr = fetch_pc_q;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = new_pc;
        end else if (imem_req) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        epc_d = epc_q;
        if (illegal_op && !branch_taken) begin
            epc_d = illegal_pc + PC_STEP;
        end

        inflight_d = imem_req;
        req_addr_d = fetch_pc_q;
        squash_d   = redirect;
    end

    // A redirect flushes the whole queue, overriding any push or pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            epc_q      <= '0;
            req_addr_q <= '0;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            epc_q      <= epc_d;
            req_addr_q <= req_addr_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= req_addr_q;
            err_mem_q[wr_ptr_q]  <= imem_err;
        end
    end

    always_comb begin
        inst_valid = (count_q != '0);
        inst       = '0;
        inst_pc    = '0;
        inst_err   = 1'b0;
        if (inst_valid) begin
            inst     = inst_mem_q[rd_ptr_q];
            inst_pc  = pc_mem_q[rd_ptr_q];
            inst_err = err_mem_q[rd_ptr_q];
        end
        epc = epc_q;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based reference model predicts every
// output each cycle while directed steps and a randomized phase drive the block.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        illegal_op;
    logic [15:0] illegal_pc;
    logic        return_execution;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_err;
    logic [15:0] epc;

    fetch_queue dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .illegal_op       (illegal_op),
        .illegal_pc       (illegal_pc),
        .return_execution (return_execution),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .imem_err         (imem_err),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .inst_err         (inst_err),
        .epc              (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
        logic        err;
    } entry_t;

    int          checks = 0;
    int          errors = 0;

    entry_t      m_q[$];
    logic [15:0] m_fetch;
    logic [15:0] m_epc;
    logic [15:0] m_infl_addr;
    logic        m_inflight;
    logic        m_hold;
    logic        m_init;

    logic [15:0] salt;
    int          err_mode;
    logic [15:0] err_addr;
    logic        last_req;
    logic [15:0] last_addr;

    logic        obs_req;
    logic        obs_valid;
    logic        obs_err;
    logic [15:0] obs_addr;
    logic [15:0] obs_inst;
    logic [15:0] obs_pc;
    logic [15:0] obs_epc;
    int          req_cnt;

    function automatic logic [15:0] memData(input logic [15:0] a);
        return a ^ salt;
    endfunction

    function automatic logic memErr(input logic [15:0] a);
        case (err_mode)
            1:       return a == err_addr;
            2:       return ((a ^ salt) & 16'h003E) == 16'h0000;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs and the memory response, compare outputs, advance the model.
    task automatic applyStimulus(input logic rst, input logic bt, input logic [15:0] tgt,
                                 input logic io, input logic [15:0] ipc, input logic re,
                                 input logic rdy);
        entry_t      head;
        entry_t      e;
        logic        redir;
        logic        exp_req;
        logic        exp_valid;
        logic [15:0] old_fetch;
        @(negedge clk);
        rst_n            = rst;
        branch_taken     = bt;
        branch_target    = tgt;
        illegal_op       = io;
        illegal_pc       = ipc;
        return_execution = re;
        inst_ready       = rdy;
        if (last_req) begin
            imem_rdata = memData(last_addr);
            imem_err   = memErr(last_addr);
        end else begin
            imem_rdata = 16'($urandom);
            imem_err   = 1'($urandom);
        end
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = inst_valid;
        obs_inst  = inst;
        obs_pc    = inst_pc;
        obs_err   = inst_err;
        obs_epc   = epc;
        last_req  = obs_req;
        last_addr = obs_addr;

        if (m_init) begin
            redir     = rst && (bt || io || re);
            exp_valid = m_q.size() != 0;
            head      = '{pc: 16'h0, data: 16'h0, err: 1'b0};
            if (exp_valid) head = m_q[0];
            exp_req = rst && !m_hold && !redir && ((m_q.size() + int'(m_inflight)) < DEPTH);
            checkOutput("imem_req", obs_req, exp_req);
            if (rst) checkOutput("imem_addr", obs_addr, m_fetch);
            checkOutput("inst_valid", obs_valid, exp_valid);
            checkOutput("inst", obs_inst, head.data);
            checkOutput("inst_pc", obs_pc, head.pc);
            checkOutput("inst_err", obs_err, head.err);
            checkOutput("epc", obs_epc, m_epc);

            if (rst) begin
                old_fetch = m_fetch;
                if (redir) begin
                    m_q.delete();
                    m_hold = 1'b0;
                    if (bt) begin
                        m_fetch = tgt;
                    end else if (io) begin
                        m_fetch = 16'h0002;
                        m_epc   = ipc + 16'd2;
                    end else begin
                        m_fetch = m_epc;
                    end
                end else begin
                    if (exp_valid && rdy) void'(m_q.pop_front());
                    if (m_inflight) begin
                        e = '{pc: m_infl_addr, data: memData(m_infl_addr), err: memErr(m_infl_addr)};
                        m_q.push_back(e);
                        if (e.err) m_hold = 1'b1;
                    end
                    if (exp_req) m_fetch = m_fetch + 16'd2;
                end
                m_inflight  = exp_req;
                m_infl_addr = old_fetch;
            end
        end

        if (!rst) begin
            m_q.delete();
            m_fetch     = 16'h0000;
            m_epc       = 16'h0000;
            m_inflight  = 1'b0;
            m_infl_addr = 16'h0000;
            m_hold      = 1'b0;
            m_init      = 1'b1;
        end
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, rdy);
    endtask

    task automatic branchTo(input logic [15:0] tgt, input logic rdy);
        applyStimulus(1'b1, 1'b1, tgt, 1'b0, 16'h0, 1'b0, rdy);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          r;
        logic        rdy;
        logic [15:0] rnd;
        rst_n            = 1'b0;
        branch_taken     = 1'b0;
        branch_target    = 16'h0;
        illegal_op       = 1'b0;
        illegal_pc       = 16'h0;
        return_execution = 1'b0;
        inst_ready       = 1'b0;
        imem_rdata       = 16'h0;
        imem_err         = 1'b0;
        m_init           = 1'b0;
        m_inflight       = 1'b0;
        m_hold           = 1'b0;
        m_fetch          = 16'h0;
        m_epc            = 16'h0;
        m_infl_addr      = 16'h0;
        salt             = 16'($urandom);
        err_mode         = 0;
        err_addr         = 16'h0;
        last_req         = 1'b0;
        last_addr        = 16'h0;

        // Streaming after reset
        doReset();
        idle(1'b1);
        checkOutput("stream_first_req", {obs_req, obs_addr}, {1'b1, 16'h0000});
        checkOutput("stream_no_valid_c0", obs_valid, 1'b0);
        idle(1'b1);
        checkOutput("stream_no_valid_c1", obs_valid, 1'b0);
        idle(1'b1);
        checkOutput("stream_first_valid", {obs_valid, obs_pc}, {1'b1, 16'h0000});
        for (int i = 1; i <= 4; i++) begin
            idle(1'b1);
            checkOutput("stream_pc", {obs_valid, obs_pc}, {1'b1, 16'(2 * i)});
        end

        // Backpressure fills exactly DEPTH entries
        doReset();
        req_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1'b0);
            if (obs_req) req_cnt++;
        end
        checkOutput("bp_req_count", req_cnt, 4);
        checkOutput("bp_stalled", {obs_req, obs_valid, obs_pc}, {1'b0, 1'b1, 16'h0000});
        idle(1'b1);
        idle(1'b0);
        checkOutput("bp_resume", {obs_req, obs_addr, obs_pc}, {1'b1, 16'h0008, 16'h0002});
        idle(1'b0);
        checkOutput("bp_single_req", obs_req, 1'b0);

        // Branch flush with a response in flight
        branchTo(16'h0010, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b0);
        branchTo(16'h0040, 1'b1);
        checkOutput("br_req_blocked", obs_req, 1'b0);
        idle(1'b1);
        checkOutput("br_first_req", {obs_req, obs_addr, obs_valid}, {1'b1, 16'h0040, 1'b0});
        idle(1'b1);
        checkOutput("br_empty_n2", obs_valid, 1'b0);
        idle(1'b1);
        checkOutput("br_valid_n3", {obs_valid, obs_pc}, {1'b1, 16'h0040});

        // Exception and return
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 16'h0020, 1'b0, 1'b1);
        idle(1'b1);
        checkOutput("exc_epc", obs_epc, 16'h0022);
        checkOutput("exc_vector", {obs_req, obs_addr}, {1'b1, 16'h0002});
        for (int i = 0; i < 4; i++) idle(1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
        idle(1'b1);
        checkOutput("ret_addr", {obs_req, obs_addr}, {1'b1, 16'h0022});
        for (int i = 0; i < 3; i++) idle(1'b1);
        applyStimulus(1'b1, 1'b1, 16'h0080, 1'b1, 16'h0030, 1'b0, 1'b1);
        idle(1'b1);
        checkOutput("br_over_exc", {obs_epc, obs_addr}, {16'h0022, 16'h0080});
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 16'h0050, 1'b1, 1'b1);
        idle(1'b1);
        checkOutput("exc_over_ret", {obs_epc, obs_addr}, {16'h0052, 16'h0002});

        // Memory error hold
        err_mode = 1;
        err_addr = 16'h0008;
        branchTo(16'h0000, 1'b1);
        for (int i = 0; i < 7; i++) idle(1'b1);
        checkOutput("err_entry", {obs_valid, obs_pc, obs_err}, {1'b1, 16'h0008, 1'b1});
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            checkOutput("err_hold_req", obs_req, 1'b0);
        end
        err_mode = 0;
        branchTo(16'h0000, 1'b1);
        idle(1'b1);
        checkOutput("err_resume", {obs_req, obs_addr}, {1'b1, 16'h0000});

        // Address wrap
        branchTo(16'hFFFC, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        checkOutput("wrap_pc0", obs_pc, 16'hFFFC);
        idle(1'b1);
        checkOutput("wrap_pc1", obs_pc, 16'hFFFE);
        idle(1'b1);
        checkOutput("wrap_pc2", obs_pc, 16'h0000);

        // Reset while a request is in flight
        idle(1'b1);
        checkOutput("pre_reset_req", obs_req, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("reset_req_low", obs_req, 1'b0);
        idle(1'b1);
        checkOutput("post_reset_out", {obs_valid, obs_inst, obs_pc, obs_err, obs_epc},
                    {1'b0, 16'h0, 16'h0, 1'b0, 16'h0});
        checkOutput("post_reset_req", {obs_req, obs_addr}, {1'b1, 16'h0000});
        idle(1'b1);
        idle(1'b1);
        checkOutput("post_reset_valid", {obs_valid, obs_pc}, {1'b1, 16'h0000});

        // Randomized traffic against the model
        err_mode = 2;
        for (int i = 0; i < 400; i++) begin
            r   = $urandom_range(0, 39);
            rdy = ($urandom_range(0, 3) != 0);
            rnd = 16'($urandom) & 16'hFFFE;
            case (r)
                0, 1: applyStimulus(1'b1, 1'b1, rnd, 1'b0, 16'h0, 1'b0, rdy);
                2:    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, rnd, 1'b0, rdy);
                3:    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, rdy);
                4:    applyStimulus(1'b1, 1'b1, rnd, 1'b1, 16'($urandom), 1'b1, rdy);
                5:    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, rdy);
                default: idle(rdy);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
